// File: rtl/switch_debounce_select.sv
// Two-switch synchroniser + debouncer producing a registered 2-bit select and a one-cycle change strobe.
// Define DEBOUNCE_TOGGLE_EN for toggle mode (each debounced press inverts that switch's select bit).
module switch_debounce_select #(
  parameter int  DEBOUNCE_LIMIT = 250000,
  localparam int CNT_WIDTH      = $clog2(DEBOUNCE_LIMIT) + 1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  output logic [1:0] o_Select,
  output logic       o_Changed
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_LIMIT - 1);

  logic [1:0]                meta_q, meta_d;
  logic [1:0]                sync_q, sync_d;
  logic [1:0]                stable_q, stable_d;
  logic [1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                      changed_q, changed_d;

  // Counter only advances while the synced level disagrees with the accepted one,
  // so any agreeing cycle restarts qualification and the count can never pass CNT_MAX.
  always_comb begin
    meta_d   = {i_Switch_2, i_Switch_1};
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = '0;
    for (int i = 0; i < 2; i++) begin
      if (sync_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = sync_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
        end
      end
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta_q    <= '0;
      sync_q    <= '0;
      stable_q  <= '0;
      cnt_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      changed_q <= changed_d;
    end
  end

`ifdef DEBOUNCE_TOGGLE_EN
  logic [1:0] sel_q, sel_d;

  // Only debounced presses (0->1) flip the select; releases just update stable_q.
  always_comb begin
    sel_d     = sel_q ^ (stable_d & ~stable_q);
    changed_d = (sel_d != sel_q);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sel_q <= '0;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign o_Select = sel_q;
`else
  always_comb begin
    changed_d = (stable_d != stable_q);
  end

  assign o_Select = stable_q;
`endif

  assign o_Changed = changed_q;

endmodule

// File: tb/tb_switch_debounce_select.sv
// Bench for switch_debounce_select with DEBOUNCE_LIMIT = 4: sliding-window model plus directed checks.
module tb_switch_debounce_select;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw1 = 1'b1;
  logic       sw2 = 1'b1;
  logic [1:0] o_Select;
  logic       o_Changed;

  int n_checks = 0;
  int n_fail   = 0;
  int chg_cnt  = 0;
  logic chk_en = 1'b0;

  switch_debounce_select #(.DEBOUNCE_LIMIT(LIMIT)) dut (
    .i_Clk      (clk),
    .i_Rst_L    (rst_n),
    .i_Switch_1 (sw1),
    .i_Switch_2 (sw2),
    .o_Select   (o_Select),
    .o_Changed  (o_Changed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  // Model: a level is accepted once the raw samples feeding the last LIMIT
  // synced cycles all agree on a value different from the accepted level.
  logic [1:0] m_stable, m_sel;
  logic       m_chg;
  logic [1:0] hist[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stable <= 2'b00;
      m_sel    <= 2'b00;
      m_chg    <= 1'b0;
      hist.delete();
      for (int k = 0; k < LIMIT + 1; k++) hist.push_back(2'b00);
    end else begin
      logic [1:0] nxt;
      logic [1:0] new_sel;
      int ones;
      nxt = m_stable;
      for (int b = 0; b < 2; b++) begin
        ones = 0;
        for (int j = 1; j <= LIMIT; j++) ones += int'(hist[hist.size() - 1 - j][b]);
        if (ones == LIMIT && !m_stable[b]) nxt[b] = 1'b1;
        if (ones == 0 && m_stable[b]) nxt[b] = 1'b0;
      end
`ifdef DEBOUNCE_TOGGLE_EN
      new_sel = m_sel ^ (nxt & ~m_stable);
`else
      new_sel = nxt;
`endif
      m_chg    <= (new_sel != m_sel);
      m_sel    <= new_sel;
      m_stable <= nxt;
      hist.push_back({sw2, sw1});
      void'(hist.pop_front());
    end
  end

  always @(posedge clk) begin
    #2;
    if (o_Changed === 1'b1) chg_cnt++;
    if (chk_en) begin
      check("model_select", o_Select, m_sel);
      check("model_changed", {1'b0, o_Changed}, {1'b0, m_chg});
    end
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int c0;
    @(posedge clk);
    chk_en = 1'b1;

`ifdef DEBOUNCE_TOGGLE_EN
    @(negedge clk);
    sw1 = 1'b0;
    sw2 = 1'b0;
    wait_edges(3);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(10);
    check("toggle_idle", o_Select, 2'b00);
    for (int p = 0; p < 3; p++) begin
      logic [1:0] exp_sel;
      exp_sel = (p % 2 == 0) ? 2'b01 : 2'b00;
      @(negedge clk);
      sw1 = 1'b1;
      wait_edges(5);
      check("toggle_before_press", o_Select, ~exp_sel & 2'b01);
      wait_edges(1);
      check("toggle_press_sel", o_Select, exp_sel);
      check("toggle_press_chg", {1'b0, o_Changed}, 2'b01);
      c0 = chg_cnt;
      @(negedge clk);
      sw1 = 1'b0;
      wait_edges(10);
      check("toggle_release_nochg", 2'(chg_cnt - c0), 2'd0);
      check("toggle_release_sel", o_Select, exp_sel);
    end
`else
    // 1: reset held with switches high, then release
    for (int k = 0; k < 5; k++) begin
      wait_edges(1);
      check("rst_select", o_Select, 2'b00);
      check("rst_changed", {1'b0, o_Changed}, 2'b00);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(5);
    check("rel_early", o_Select, 2'b00);
    wait_edges(1);
    check("rel_select", o_Select, 2'b11);
    check("rel_changed", {1'b0, o_Changed}, 2'b01);
    wait_edges(1);
    check("rel_changed_drop", {1'b0, o_Changed}, 2'b00);

    // 2: clean rise on switch 1
    @(negedge clk);
    sw1 = 1'b0;
    sw2 = 1'b0;
    wait_edges(10);
    check("sw1_idle", o_Select, 2'b00);
    @(negedge clk);
    sw1 = 1'b1;
    wait_edges(5);
    check("sw1_early", o_Select, 2'b00);
    wait_edges(1);
    check("sw1_select", o_Select, 2'b01);
    check("sw1_changed", {1'b0, o_Changed}, 2'b01);
    wait_edges(1);
    check("sw1_changed_drop", {1'b0, o_Changed}, 2'b00);

    // 3: bounce on switch 2 is rejected, then a held level is accepted
    @(negedge clk);
    sw1 = 1'b0;
    wait_edges(10);
    check("bounce_idle", o_Select, 2'b00);
    c0 = chg_cnt;
    for (int len = 1; len <= 3; len++) begin
      @(negedge clk);
      sw2 = 1'b1;
      repeat (len) @(negedge clk);
      sw2 = 1'b0;
      repeat (3) @(negedge clk);
    end
    wait_edges(4);
    check("bounce_select", o_Select, 2'b00);
    check("bounce_nochg", 2'(chg_cnt - c0), 2'd0);
    @(negedge clk);
    sw2 = 1'b1;
    wait_edges(5);
    check("sw2_early", o_Select, 2'b00);
    wait_edges(1);
    check("sw2_select", o_Select, 2'b10);
    check("sw2_changed", {1'b0, o_Changed}, 2'b01);

    // 4: both switches rise together
    @(negedge clk);
    sw2 = 1'b0;
    wait_edges(10);
    check("both_idle", o_Select, 2'b00);
    c0 = chg_cnt;
    @(negedge clk);
    sw1 = 1'b1;
    sw2 = 1'b1;
    wait_edges(5);
    check("both_early", o_Select, 2'b00);
    wait_edges(1);
    check("both_select", o_Select, 2'b11);
    wait_edges(4);
    check("both_one_pulse", 2'(chg_cnt - c0), 2'd1);

    // 5: reset mid-count discards the partial qualification
    @(negedge clk);
    sw1 = 1'b0;
    sw2 = 1'b1;
    wait_edges(10);
    check("midrst_pre", o_Select, 2'b10);
    @(negedge clk);
    sw1 = 1'b1;
    wait_edges(4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_select", o_Select, 2'b00);
    check("midrst_changed", {1'b0, o_Changed}, 2'b00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_edges(5);
    check("midrst_early", o_Select, 2'b00);
    wait_edges(1);
    check("midrst_select_after", o_Select, 2'b11);
    check("midrst_changed_after", {1'b0, o_Changed}, 2'b01);
`endif

    wait_edges(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
